// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated two-road junction phase scheduler: green extension, yellow,
// all-red clearance and an optional pedestrian walk phase, Moore-decoded lamps.
module traffic_phase_scheduler #(
  parameter int CW        = 4,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW    = 3,
  parameter int ALLRED    = 1,
  parameter int WALK      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_a,
  input  logic       car_b,
  input  logic       ped_req,
  input  logic       hold,
  output logic [2:0] LightA,
  output logic [2:0] LightB,
  output logic       walk,
  output logic [2:0] phase
);

  localparam logic [2:0] S_A_GRN = 3'b000;
  localparam logic [2:0] S_A_YEL = 3'b001;
  localparam logic [2:0] S_AR1   = 3'b010;
  localparam logic [2:0] S_B_GRN = 3'b011;
  localparam logic [2:0] S_B_YEL = 3'b100;
  localparam logic [2:0] S_AR2   = 3'b101;
  localparam logic [2:0] S_WALK  = 3'b110;

  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_RED = 3'b100;

  localparam logic [CW-1:0] GMIN_C   = CW'(GREEN_MIN);
  localparam logic [CW-1:0] GMAX_C   = CW'(GREEN_MAX);
  localparam logic [CW-1:0] YEL_C    = CW'(YELLOW);
  localparam logic [CW-1:0] ALLRED_C = CW'(ALLRED);
  localparam logic [CW-1:0] WALK_C   = CW'(WALK);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ped_pend_q, ped_pend_d;
  logic          nxt_b_q, nxt_b_d;

  logic          ped_any;
  logic [CW-1:0] cnt_inc;

  assign ped_any = ped_pend_q | ped_req;
  assign cnt_inc = cnt_q + ONE_C;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ped_pend_d = ped_pend_q;
    nxt_b_d    = nxt_b_q;
    if (!hold) begin
      // Request latch is evaluated first so that entering WALK below clears it.
      if (ped_req && (state_q != S_WALK)) ped_pend_d = 1'b1;
      case (state_q)
        S_A_GRN: begin
          if ((cnt_q >= GMIN_C) && (car_b | ped_any) && (!car_a || (cnt_q == GMAX_C))) begin
            state_d = S_A_YEL;
            cnt_d   = ONE_C;
          end else if (cnt_q < GMAX_C) begin
            cnt_d = cnt_inc;
          end
        end
        S_A_YEL: begin
          if (cnt_q == YEL_C) begin
            state_d = S_AR1;
            cnt_d   = ONE_C;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_AR1: begin
          nxt_b_d = 1'b0;
          if (cnt_q == ALLRED_C) begin
            cnt_d = ONE_C;
            if (ped_any) begin
              state_d    = S_WALK;
              ped_pend_d = 1'b0;
            end else begin
              state_d = S_B_GRN;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_B_GRN: begin
          if ((cnt_q >= GMIN_C) && (car_a | ped_any) && (!car_b || (cnt_q == GMAX_C))) begin
            state_d = S_B_YEL;
            cnt_d   = ONE_C;
          end else if (cnt_q < GMAX_C) begin
            cnt_d = cnt_inc;
          end
        end
        S_B_YEL: begin
          if (cnt_q == YEL_C) begin
            state_d = S_AR2;
            cnt_d   = ONE_C;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_AR2: begin
          nxt_b_d = 1'b1;
          if (cnt_q == ALLRED_C) begin
            cnt_d = ONE_C;
            if (ped_any) begin
              state_d    = S_WALK;
              ped_pend_d = 1'b0;
            end else begin
              state_d = S_A_GRN;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_WALK: begin
          if (cnt_q == WALK_C) begin
            state_d = nxt_b_q ? S_A_GRN : S_B_GRN;
            cnt_d   = ONE_C;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = S_A_GRN;
          cnt_d   = ONE_C;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_A_GRN;
      cnt_q      <= ONE_C;
      ped_pend_q <= 1'b0;
      nxt_b_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ped_pend_q <= ped_pend_d;
      nxt_b_q    <= nxt_b_d;
    end
  end

  always_comb begin
    LightA = LAMP_RED;
    LightB = LAMP_RED;
    walk   = 1'b0;
    case (state_q)
      S_A_GRN: LightA = LAMP_GRN;
      S_A_YEL: LightA = LAMP_YEL;
      S_B_GRN: LightB = LAMP_GRN;
      S_B_YEL: LightB = LAMP_YEL;
      S_WALK:  walk   = 1'b1;
      default: ;
    endcase
  end

  assign phase = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed-vector bench for traffic_phase_scheduler; cycle n is the cycle
// ending at the n-th rising edge after the reset edge.
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       reset, car_a, car_b, ped_req, hold;
  logic [2:0] LightA, LightB, phase;
  logic       walk;

  int n_pass  = 0;
  int n_total = 0;

  traffic_phase_scheduler #(
    .CW(4), .GREEN_MIN(4), .GREEN_MAX(10), .YELLOW(3), .ALLRED(1), .WALK(5)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .car_a  (car_a),
    .car_b  (car_b),
    .ped_req(ped_req),
    .hold   (hold),
    .LightA (LightA),
    .LightB (LightB),
    .walk   (walk),
    .phase  (phase)
  );

  always #5 clk = ~clk;

  // Expected {LightA, LightB, walk} for a phase code.
  function automatic logic [6:0] lamps(input logic [2:0] ph);
    case (ph)
      3'b000:  return {3'b001, 3'b100, 1'b0};
      3'b001:  return {3'b010, 3'b100, 1'b0};
      3'b010:  return {3'b100, 3'b100, 1'b0};
      3'b011:  return {3'b100, 3'b001, 1'b0};
      3'b100:  return {3'b100, 3'b010, 1'b0};
      3'b101:  return {3'b100, 3'b100, 1'b0};
      3'b110:  return {3'b100, 3'b100, 1'b1};
      default: return {3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; car_a = 1'b0; car_b = 1'b0; ped_req = 1'b0; hold = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] obs, expv;
    reset = 1'b1; hold = 1'b1; ped_req = 1'b1; car_a = 1'b1; car_b = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      expv = {lamps(3'b000), 3'b000};
      obs  = {LightA, LightB, walk, phase};
      n_total++;
      if (obs !== expv)
        $display("FAIL reset cycle %0d: got %b expected %b", c, obs, expv);
      else n_pass++;
      tick();
    end
    hold = 1'b0; ped_req = 1'b0; car_a = 1'b0; car_b = 1'b0;
  endtask

  task automatic test_idle();
    logic [9:0] obs, expv;
    do_reset();
    for (int c = 1; c <= 50; c++) begin
      expv = {lamps(3'b000), 3'b000};
      obs  = {LightA, LightB, walk, phase};
      n_total++;
      if (obs !== expv)
        $display("FAIL idle cycle %0d: got %b expected %b", c, obs, expv);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_car_b();
    logic [9:0] obs, expv;
    logic [2:0] e;
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      car_b = 1'b1;
      e = (c <= 4) ? 3'b000 : (c <= 7) ? 3'b001 : (c == 8) ? 3'b010 : 3'b011;
      expv = {lamps(e), e};
      obs  = {LightA, LightB, walk, phase};
      n_total++;
      if (obs !== expv)
        $display("FAIL car_b cycle %0d: got %b expected %b", c, obs, expv);
      else n_pass++;
      tick();
    end
    car_b = 1'b0;
  endtask

  task automatic test_both_cars();
    logic [9:0] obs, expv;
    logic [2:0] e;
    int p;
    do_reset();
    for (int c = 1; c <= 60; c++) begin
      car_a = 1'b1; car_b = 1'b1;
      p = (c - 1) % 28;
      e = (p <= 9)  ? 3'b000 : (p <= 12) ? 3'b001 : (p == 13) ? 3'b010 :
          (p <= 23) ? 3'b011 : (p <= 26) ? 3'b100 : 3'b101;
      expv = {lamps(e), e};
      obs  = {LightA, LightB, walk, phase};
      n_total++;
      if (obs !== expv)
        $display("FAIL both_cars cycle %0d: got %b expected %b", c, obs, expv);
      else n_pass++;
      tick();
    end
    car_a = 1'b0; car_b = 1'b0;
  endtask

  // extra_pulse: cycle of a second request issued during WALK (0 = none); it must be ignored.
  task automatic test_ped(input int extra_pulse);
    logic [9:0] obs, expv;
    logic [2:0] e;
    do_reset();
    for (int c = 1; c <= 25; c++) begin
      ped_req = (c == 2) || (c == extra_pulse);
      e = (c <= 4) ? 3'b000 : (c <= 7) ? 3'b001 : (c == 8) ? 3'b010 :
          (c <= 13) ? 3'b110 : 3'b011;
      expv = {lamps(e), e};
      obs  = {LightA, LightB, walk, phase};
      n_total++;
      if (obs !== expv)
        $display("FAIL ped(extra=%0d) cycle %0d: got %b expected %b", extra_pulse, c, obs, expv);
      else n_pass++;
      tick();
    end
    ped_req = 1'b0;
  endtask

  task automatic test_hold();
    logic [9:0] obs, expv;
    logic [2:0] e;
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      car_b = 1'b1;
      hold  = (c >= 6) && (c <= 10);
      e = (c <= 4) ? 3'b000 : (c <= 12) ? 3'b001 : (c == 13) ? 3'b010 : 3'b011;
      expv = {lamps(e), e};
      obs  = {LightA, LightB, walk, phase};
      n_total++;
      if (obs !== expv)
        $display("FAIL hold cycle %0d: got %b expected %b", c, obs, expv);
      else n_pass++;
      tick();
    end
    car_b = 1'b0; hold = 1'b0;
  endtask

  task automatic test_hold_ped();
    logic [9:0] obs, expv;
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      hold    = (c >= 2) && (c <= 4);
      ped_req = (c >= 2) && (c <= 4);
      expv = {lamps(3'b000), 3'b000};
      obs  = {LightA, LightB, walk, phase};
      n_total++;
      if (obs !== expv)
        $display("FAIL hold_ped cycle %0d: got %b expected %b", c, obs, expv);
      else n_pass++;
      tick();
    end
    hold = 1'b0; ped_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [9:0] obs, expv;
    logic [2:0] e;
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      car_b   = 1'b1;
      ped_req = (c == 11);
      reset   = (c == 12);
      e = (c <= 4) ? 3'b000 : (c <= 7) ? 3'b001 : (c == 8) ? 3'b010 : 3'b011;
      expv = {lamps(e), e};
      obs  = {LightA, LightB, walk, phase};
      n_total++;
      if (obs !== expv)
        $display("FAIL reset_mid pre cycle %0d: got %b expected %b", c, obs, expv);
      else n_pass++;
      tick();
    end
    reset = 1'b0; car_b = 1'b0; ped_req = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      expv = {lamps(3'b000), 3'b000};
      obs  = {LightA, LightB, walk, phase};
      n_total++;
      if (obs !== expv)
        $display("FAIL reset_mid post cycle %0d: got %b expected %b", c, obs, expv);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_walk_to_a();
    logic [9:0] obs, expv;
    logic [2:0] e;
    do_reset();
    for (int c = 1; c <= 30; c++) begin
      car_b   = (c <= 9);
      car_a   = (c >= 9);
      ped_req = (c == 10);
      e = (c <= 4)  ? 3'b000 : (c <= 7)  ? 3'b001 : (c == 8)  ? 3'b010 :
          (c <= 12) ? 3'b011 : (c <= 15) ? 3'b100 : (c == 16) ? 3'b101 :
          (c <= 21) ? 3'b110 : 3'b000;
      expv = {lamps(e), e};
      obs  = {LightA, LightB, walk, phase};
      n_total++;
      if (obs !== expv)
        $display("FAIL walk_to_a cycle %0d: got %b expected %b", c, obs, expv);
      else n_pass++;
      tick();
    end
    car_a = 1'b0; car_b = 1'b0; ped_req = 1'b0;
  endtask

  initial begin
    reset = 1'b0; car_a = 1'b0; car_b = 1'b0; ped_req = 1'b0; hold = 1'b0;
    #2;
    test_reset();
    test_idle();
    test_car_b();
    test_both_cars();
    test_ped(0);
    test_ped(10);
    test_hold();
    test_hold_ped();
    test_reset_mid();
    test_walk_to_a();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
